// File: rtl/truth_table_sweeper.sv
// Drives a 4-input gate through all 16 vectors and assembles its truth table.
// Compares the measured table against an expected function latched at start.
module truth_table_sweeper #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [15:0] i_expected,
    output logic [3:0]  o_dut_in,
    input  logic        i_dut_out,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_table,
    output logic [4:0]  o_mismatch_count,
    output logic [3:0]  o_first_fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_FIN
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t      r_state;
    logic [15:0] r_exp;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [15:0] r_table;
    logic [4:0]  r_mis;
    logic [3:0]  r_ffi;

    logic        w_miss;
    logic [4:0]  w_mis_next;

    assign w_miss     = i_dut_out != r_exp[r_idx];
    assign w_mis_next = r_mis + {4'd0, w_miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_table <= '0;
            r_mis   <= '0;
            r_ffi   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_exp   <= i_expected;
                        r_table <= '0;
                        r_mis   <= '0;
                        r_ffi   <= '0;
                        r_pass  <= 1'b0;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_table[r_idx] <= i_dut_out;
                    r_mis          <= w_mis_next;
                    if (w_miss && r_mis == 5'd0) begin
                        r_ffi <= r_idx;
                    end
                    // pass must be visible alongside done, so use the next count
                    if (r_idx == 4'd15) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_mis_next == 5'd0);
                        r_state <= S_FIN;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_cnt   <= '0;
                        r_state <= S_DRIVE;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_dut_in         = r_idx;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_table          = r_table;
    assign o_mismatch_count = r_mis;
    assign o_first_fail_idx = r_ffi;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: combinational, stuck-at-1 and registered gate models
// around two sweeper instances (SETTLE=2 and SETTLE=1).
module tb_truth_table_sweeper;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_expected;
    logic [15:0] func;
    logic        stuck1;

    logic [3:0]  d0_in;
    logic        d0_out;
    logic        d0_busy, d0_done, d0_pass;
    logic [15:0] d0_table;
    logic [4:0]  d0_mis;
    logic [3:0]  d0_ffi;

    logic        i_start1;
    logic [3:0]  d1_in;
    logic        d1_out;
    logic        d1_busy, d1_done, d1_pass;
    logic [15:0] d1_table;
    logic [4:0]  d1_mis;
    logic [3:0]  d1_ffi;
    logic        r_g1;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign d0_out = stuck1 ? 1'b1 : func[d0_in];

    always_ff @(posedge clk) r_g1 <= func[d1_in];
    assign d1_out = r_g1;

    truth_table_sweeper #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_expected(i_expected), .o_dut_in(d0_in), .i_dut_out(d0_out),
        .o_busy(d0_busy), .o_done(d0_done), .o_pass(d0_pass),
        .o_table(d0_table), .o_mismatch_count(d0_mis),
        .o_first_fail_idx(d0_ffi)
    );

    truth_table_sweeper #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start1),
        .i_expected(i_expected), .o_dut_in(d1_in), .i_dut_out(d1_out),
        .o_busy(d1_busy), .o_done(d1_done), .o_pass(d1_pass),
        .o_table(d1_table), .o_mismatch_count(d1_mis),
        .o_first_fail_idx(d1_ffi)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // lat counts rising edges with the start-sampling edge as 1
    task automatic sweep0(input logic [15:0] ex, input bit poke,
                          output int lat, output int bcnt, output int both);
        @(negedge clk);
        i_expected = ex;
        i_start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        lat  = 1;
        bcnt = 0;
        both = 0;
        while (!d0_done && lat < 200) begin
            if (d0_busy) bcnt++;
            if (d0_busy && d0_done) both++;
            i_start = poke && (lat == 5 || lat == 20);
            if (poke && lat == 10) i_expected = 16'h0000;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        i_start = 1'b0;
        if (d0_busy && d0_done) both++;
    endtask

    task automatic check_result(input string tag, input logic [15:0] tbl,
                                input logic pass, input logic [4:0] mis,
                                input logic [3:0] ffi);
        chk({tag, "_table"}, 32'(d0_table), 32'(tbl));
        chk({tag, "_pass"}, 32'(d0_pass), 32'(pass));
        chk({tag, "_mis"}, 32'(d0_mis), 32'(mis));
        chk({tag, "_ffi"}, 32'(d0_ffi), 32'(ffi));
    endtask

    initial begin
        int lat, bcnt, both, seen_done, n;
        logic [3:0] trace [32];
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_start1   = 1'b0;
        i_expected = 16'h0;
        func       = 16'h2FC7;
        stuck1     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(d0_busy), 0);
        chk("rst_done", 32'(d0_done), 0);
        chk("rst_dut_in", 32'(d0_in), 0);
        chk("rst_table", 32'(d0_table), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        sweep0(16'h2FC7, 1'b0, lat, bcnt, both);
        chk("good_lat", 32'(lat), 49);
        chk("good_busy_len", 32'(bcnt), 48);
        chk("good_busy_done", 32'(both), 0);
        check_result("good", 16'h2FC7, 1'b1, 5'd0, 4'd0);
        @(negedge clk);
        chk("done_pulse", 32'(d0_done), 0);
        chk("idle_dut_in", 32'(d0_in), 0);
        chk("hold_table", 32'(d0_table), 32'h2FC7);
        chk("hold_pass", 32'(d0_pass), 1);

        sweep0(16'h2FC6, 1'b0, lat, bcnt, both);
        check_result("bit0", 16'h2FC7, 1'b0, 5'd1, 4'd0);

        sweep0(16'hD038, 1'b0, lat, bcnt, both);
        check_result("inv", 16'h2FC7, 1'b0, 5'd16, 4'd0);

        stuck1 = 1'b1;
        sweep0(16'hFF7F, 1'b0, lat, bcnt, both);
        check_result("sa1", 16'hFFFF, 1'b0, 5'd1, 4'd7);
        stuck1 = 1'b0;

        sweep0(16'h2FC7, 1'b1, lat, bcnt, both);
        chk("poke_lat", 32'(lat), 49);
        chk("poke_busy_len", 32'(bcnt), 48);
        check_result("poke", 16'h2FC7, 1'b1, 5'd0, 4'd0);

        // abort at cycle 30
        @(negedge clk);
        i_expected = 16'h2FC7;
        i_start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_abort_busy", 32'(d0_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(d0_busy), 0);
        chk("abort_dut_in", 32'(d0_in), 0);
        chk("abort_table", 32'(d0_table), 0);
        chk("abort_mis", 32'(d0_mis), 0);
        chk("abort_ffi", 32'(d0_ffi), 0);
        chk("abort_pass", 32'(d0_pass), 0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (d0_done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (d0_done || d0_busy) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 0);
        sweep0(16'h2FC7, 1'b0, lat, bcnt, both);
        chk("after_abort_lat", 32'(lat), 49);
        check_result("after_abort", 16'h2FC7, 1'b1, 5'd0, 4'd0);

        // registered gate, SETTLE=1
        @(negedge clk);
        i_expected = 16'h2FC7;
        i_start1   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_start1 = 1'b0;
        n   = 0;
        lat = 1;
        while (!d1_done && lat < 200) begin
            if (d1_busy && n < 32) begin
                trace[n] = d1_in;
                n++;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("reg_lat", 32'(lat), 33);
        chk("reg_busy_len", 32'(n), 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("reg_dut_in_%0d", i), 32'(trace[i]), 32'(i / 2));
        end
        chk("reg_table", 32'(d1_table), 32'h2FC7);
        chk("reg_pass", 32'(d1_pass), 1);
        chk("reg_mis", 32'(d1_mis), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
